// File: rtl/mmio_io_controller_pkg.sv
// MMIO controller shared definitions:
// default register map and control/status helpers.
package mmio_pkg;

  localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0020;
  localparam logic [31:0] ADDR_TLIM  = 32'hF000_0024;
  localparam logic [31:0] ADDR_TCTL  = 32'hF000_0120;

  localparam int CTRL_READY_BIT   = 0;
  localparam int CTRL_OVERRUN_BIT = 2;

  typedef struct packed {
    logic ovr;
    logic ready;
  } ctrl_t;

  // An event always wins over a clear for ready; a read clear in
  // the same cycle keeps a pending overrun from being raised.
  function automatic ctrl_t ctrl_next(
    input ctrl_t c,
    input logic  ev,
    input logic  clr,
    input logic  wr,
    input logic  w_rdy,
    input logic  w_ovr
  );
    ctrl_t n;
    n = c;
    if (wr && !w_ovr) n.ovr = 1'b0;
    if (wr && !w_rdy) n.ready = 1'b0;
    if (clr) n.ready = 1'b0;
    if (ev) begin
      if (c.ready && !clr) n.ovr = 1'b1;
      n.ready = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [2:0] ctrl_bits(input ctrl_t c);
    logic [2:0] b;
    b = '0;
    b[CTRL_READY_BIT]   = c.ready;
    b[CTRL_OVERRUN_BIT] = c.ovr;
    return b;
  endfunction

endpackage

// File: rtl/mmio_io_controller_if.sv
// CPU data-port bus into the MMIO controller.
// Master drives address/strobes, slave answers read data.
interface mmio_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             wr_en;
  logic             rd_en;
  logic [DBITS-1:0] wr_data;
  logic [DBITS-1:0] rd_data;
  logic             io_sel;

  modport master (
    output addr, wr_en, rd_en, wr_data,
    input  rd_data, io_sel
  );

  modport slave (
    input  addr, wr_en, rd_en, wr_data,
    output rd_data, io_sel
  );
endinterface

// File: rtl/mmio_io_controller_sync_debounce.sv
// Two-flop synchroniser plus debouncer for board inputs;
// change pulses in the cycle the debounced value is updated.
module io_sync_debounce #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 4,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value,
  output logic             change
);
  localparam int CW = $clog2(CYCLES + 2);

  logic [WIDTH-1:0] s1, s2, cand;
  logic [CW-1:0]    cnt, run;
  logic             accept;

  // run counts consecutive cycles the synced input has held
  assign run    = (s2 == cand) ? cnt + CW'(1) : CW'(1);
  assign accept = run >= CW'(CYCLES);
  assign change = accept && (s2 != value);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      cnt   <= '0;
      value <= '0;
    end else begin
      s1   <= INVERT ? ~raw : raw;
      s2   <= s1;
      cand <= s2;
      cnt  <= accept ? CW'(CYCLES) : run;
      if (change) value <= s2;
    end
  end
endmodule

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O block: HEX/LEDR outputs, debounced
// KEY/SW inputs with ready/overrun status, interval timer.
module mmio_io_controller
  import mmio_pkg::*;
#(
  parameter int          DBITS           = 32,
  parameter int          HEX_BITS        = 16,
  parameter int          LEDR_BITS       = 10,
  parameter int          KEY_BITS        = 4,
  parameter int          SW_BITS         = 10,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          TICK_CYCLES     = 50000,
  parameter logic [31:0] A_HEX           = ADDR_HEX,
  parameter logic [31:0] A_LEDR          = ADDR_LEDR,
  parameter logic [31:0] A_KDATA         = ADDR_KDATA,
  parameter logic [31:0] A_SDATA         = ADDR_SDATA,
  parameter logic [31:0] A_KCTRL         = ADDR_KCTRL,
  parameter logic [31:0] A_SCTRL         = ADDR_SCTRL,
  parameter logic [31:0] A_TCNT          = ADDR_TCNT,
  parameter logic [31:0] A_TLIM          = ADDR_TLIM,
  parameter logic [31:0] A_TCTL          = ADDR_TCTL
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_if.slave                bus,
  input  logic [KEY_BITS-1:0]  key_in,
  input  logic [SW_BITS-1:0]   sw_in,
  output logic [HEX_BITS-1:0]  hex_out,
  output logic [LEDR_BITS-1:0] ledr_out,
  output logic                 timer_irq
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic h_hex, h_ledr, h_kdat, h_sdat;
  logic h_kctl, h_sctl, h_tcnt, h_tlim, h_tctl;

  assign h_hex  = bus.addr == DBITS'(A_HEX);
  assign h_ledr = bus.addr == DBITS'(A_LEDR);
  assign h_kdat = bus.addr == DBITS'(A_KDATA);
  assign h_sdat = bus.addr == DBITS'(A_SDATA);
  assign h_kctl = bus.addr == DBITS'(A_KCTRL);
  assign h_sctl = bus.addr == DBITS'(A_SCTRL);
  assign h_tcnt = bus.addr == DBITS'(A_TCNT);
  assign h_tlim = bus.addr == DBITS'(A_TLIM);
  assign h_tctl = bus.addr == DBITS'(A_TCTL);

  assign bus.io_sel = h_hex | h_ledr | h_kdat | h_sdat
                    | h_kctl | h_sctl | h_tcnt | h_tlim | h_tctl;

  logic [KEY_BITS-1:0] kdata;
  logic [SW_BITS-1:0]  sdata;
  logic                kev, sev, tev;
  ctrl_t               kctl, sctl, tctl;
  logic [DBITS-1:0]    tcnt, tlim;
  logic [PW-1:0]       presc;
  logic                tick, wrap;

  io_sync_debounce #(
    .WIDTH (KEY_BITS),
    .CYCLES(DEBOUNCE_CYCLES),
    .INVERT(KEY_ACTIVE_LOW)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .raw   (key_in),
    .value (kdata),
    .change(kev)
  );

  io_sync_debounce #(
    .WIDTH (SW_BITS),
    .CYCLES(DEBOUNCE_CYCLES),
    .INVERT(1'b0)
  ) u_sw (
    .clk   (clk),
    .reset (reset),
    .raw   (sw_in),
    .value (sdata),
    .change(sev)
  );

  always_comb begin
    bus.rd_data = '0;
    unique case (1'b1)
      h_hex:   bus.rd_data = DBITS'(hex_out);
      h_ledr:  bus.rd_data = DBITS'(ledr_out);
      h_kdat:  bus.rd_data = DBITS'(kdata);
      h_sdat:  bus.rd_data = DBITS'(sdata);
      h_kctl:  bus.rd_data = DBITS'(ctrl_bits(kctl));
      h_sctl:  bus.rd_data = DBITS'(ctrl_bits(sctl));
      h_tcnt:  bus.rd_data = tcnt;
      h_tlim:  bus.rd_data = tlim;
      h_tctl:  bus.rd_data = DBITS'(ctrl_bits(tctl));
      default: bus.rd_data = '0;
    endcase
  end

  logic w_tcnt, w_tlim;
  assign w_tcnt = bus.wr_en && h_tcnt;
  assign w_tlim = bus.wr_en && h_tlim;

  // CPU writes to the timer suppress that cycle's advance
  assign tick = presc == PW'(TICK_CYCLES - 1);
  assign wrap = tick && (tlim != '0) && (tcnt == tlim - DBITS'(1));
  assign tev  = wrap && !w_tcnt && !w_tlim;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
    end else begin
      if (bus.wr_en && h_hex)  hex_out  <= bus.wr_data[HEX_BITS-1:0];
      if (bus.wr_en && h_ledr) ledr_out <= bus.wr_data[LEDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      tlim  <= '0;
      presc <= '0;
    end else if (w_tlim) begin
      tlim  <= bus.wr_data;
      tcnt  <= '0;
      presc <= '0;
    end else if (w_tcnt) begin
      tcnt  <= bus.wr_data;
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) tcnt <= wrap ? '0 : tcnt + DBITS'(1);
    end
  end

  logic w_rdy, w_ovr;
  assign w_rdy = bus.wr_data[CTRL_READY_BIT];
  assign w_ovr = bus.wr_data[CTRL_OVERRUN_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kctl <= '0;
      sctl <= '0;
      tctl <= '0;
    end else begin
      kctl <= ctrl_next(kctl, kev, bus.rd_en && h_kdat,
                        bus.wr_en && h_kctl, w_rdy, w_ovr);
      sctl <= ctrl_next(sctl, sev, bus.rd_en && h_sdat,
                        bus.wr_en && h_sctl, w_rdy, w_ovr);
      tctl <= ctrl_next(tctl, tev, 1'b0,
                        bus.wr_en && h_tctl, w_rdy, w_ovr);
    end
  end

  assign timer_irq = tctl.ready;
endmodule

// File: tb/tb_mmio_io_controller.sv
// Directed bench for mmio_io_controller with short
// debounce (4) and timer prescale (3).
module tb_mmio_io_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [9:0] sw_in;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic        timer_irq;
  int checks = 0;
  int errors = 0;

  mmio_if #(.DBITS(32)) bus ();

  mmio_io_controller #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .key_in   (key_in),
    .sw_in    (sw_in),
    .hex_out  (hex_out),
    .ledr_out (ledr_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.addr = a;
    #1;
  endtask

  task automatic rd_strobe(input logic [31:0] a);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.addr    = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    key_in      = 4'hF;
    sw_in       = '0;
    cyc(2);
    reset = 1'b0;

    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_ledr", 32'(ledr_out), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    rd(32'hF000_0014); chk("rst_sdata", bus.rd_data, 32'h0);
    rd(32'hF000_0020); chk("rst_tcnt", bus.rd_data, 32'h0);

    wr(32'hF000_0000, 32'h0001_ABCD);
    chk("hex_out", 32'(hex_out), 32'h0000_ABCD);
    rd(32'hF000_0000); chk("hex_rd", bus.rd_data, 32'h0000_ABCD);
    chk("hex_sel", 32'(bus.io_sel), 32'h1);
    wr(32'hF000_0004, 32'h0000_03FF);
    chk("ledr_out", 32'(ledr_out), 32'h3FF);
    rd(32'hF000_0004); chk("ledr_rd", bus.rd_data, 32'h3FF);
    wr(32'hF000_0010, 32'h0000_0123);
    rd(32'hF000_0010); chk("kdata_ro", bus.rd_data, 32'h0);
    rd(32'h0000_1000); chk("unmap_rd", bus.rd_data, 32'h0);
    chk("unmap_sel", 32'(bus.io_sel), 32'h0);
    rd(32'hF000_0120); chk("tctl_free", bus.rd_data, 32'h0);

    sw_in = 10'h155;
    cyc(5);
    rd(32'hF000_0014); chk("sw_early", bus.rd_data, 32'h0);
    cyc(1);
    rd(32'hF000_0014); chk("sw_data", bus.rd_data, 32'h155);
    rd(32'hF000_0114); chk("sctrl_rdy", bus.rd_data, 32'h1);

    sw_in = 10'h0AA;
    cyc(3);
    sw_in = 10'h155;
    cyc(8);
    rd(32'hF000_0014); chk("glitch_dat", bus.rd_data, 32'h155);
    rd(32'hF000_0114); chk("glitch_ctl", bus.rd_data, 32'h1);

    sw_in = 10'h2AA;
    cyc(6);
    rd(32'hF000_0014); chk("sw_data2", bus.rd_data, 32'h2AA);
    rd(32'hF000_0114); chk("sctrl_ovr", bus.rd_data, 32'h5);
    rd_strobe(32'hF000_0014);
    rd(32'hF000_0114); chk("sctrl_rdclr", bus.rd_data, 32'h4);
    wr(32'hF000_0114, 32'h0);
    rd(32'hF000_0114); chk("sctrl_wclr", bus.rd_data, 32'h0);

    wr(32'hF000_0024, 32'h2);
    rd(32'hF000_0024); chk("tlim_rd", bus.rd_data, 32'h2);
    cyc(5);
    rd(32'hF000_0120); chk("tctl_early", bus.rd_data, 32'h0);
    cyc(1);
    rd(32'hF000_0120); chk("tctl_wrap", bus.rd_data, 32'h1);
    chk("irq_wrap", 32'(timer_irq), 32'h1);
    rd(32'hF000_0020); chk("tcnt_wrap", bus.rd_data, 32'h0);
    cyc(6);
    rd(32'hF000_0120); chk("tctl_ovr", bus.rd_data, 32'h5);
    wr(32'hF000_0120, 32'h0);
    rd(32'hF000_0120); chk("tctl_wclr", bus.rd_data, 32'h0);

    key_in = 4'hE;
    cyc(6);
    rd(32'hF000_0010); chk("key_press", bus.rd_data, 32'h1);
    rd(32'hF000_0110); chk("kctrl_rdy", bus.rd_data, 32'h1);
    key_in = 4'hF;
    cyc(5);
    rd(32'hF000_0010); chk("key_hold", bus.rd_data, 32'h1);
    rd_strobe(32'hF000_0010);
    rd(32'hF000_0010); chk("key_rel", bus.rd_data, 32'h0);
    rd(32'hF000_0110); chk("kctrl_race", bus.rd_data, 32'h1);

    #2;
    reset = 1'b1;
    #1;
    chk("mid_hex", 32'(hex_out), 32'h0);
    chk("mid_ledr", 32'(ledr_out), 32'h0);
    chk("mid_irq", 32'(timer_irq), 32'h0);
    rd(32'hF000_0014); chk("mid_sdata", bus.rd_data, 32'h0);
    rd(32'hF000_0024); chk("mid_tlim", bus.rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
